// File: rtl/uart_pkg.sv
// Shared types for the UART RX controller: FSM states, FIFO entry layout and
// error-flag bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic       sb_err;
    logic       pb_err;
    logic [7:0] data;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);
  localparam int PB_BIT  = 0;
  localparam int SB_BIT  = 1;

endpackage

// File: rtl/uart_byte_fifo.sv
// Parameterized synchronous FIFO with a combinational head read and an
// occupancy counter; DEPTH must be a power of two.
module uart_byte_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by the pointers and level,
  // so stale words are never observable and the array maps onto plain flops/RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: gates RX_en, queues frames, counts errors, idle timeout.
// Optional UART_RX_CTRL_DISCARD_ERR_EN drops frames carrying parity/stop errors.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  parameter int TMO_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clr_stats,
  input  logic [TMO_W-1:0]              tmo_cycles,
  output logic                          rx_en,
  input  logic                          rx_data_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_pb_error,
  input  logic                          rx_sb_error,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic [1:0]                    out_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              pb_err_cnt,
  output logic [CNT_W-1:0]              sb_err_cnt,
  output logic                          overflow,
  output logic                          idle_tmo
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  rx_state_t        state;
  rx_entry_t        wr_entry;
  rx_entry_t        head;
  logic             full;
  logic             empty;
  logic             push_req;
  logic             push_fire;
  logic             pop_fire;
  logic [LW-1:0]    level_next;
  logic             hold_lvl;
  logic [TMO_W-1:0] tmo_cnt;

  assign wr_entry = '{sb_err: rx_sb_error, pb_err: rx_pb_error, data: rx_data};

`ifdef UART_RX_CTRL_DISCARD_ERR_EN
  assign push_req = rx_data_ready && !rx_pb_error && !rx_sb_error;
  assign out_err  = 2'b00;
`else
  assign push_req = rx_data_ready;
  assign out_err  = {head.sb_err, head.pb_err};
`endif

  assign out_valid = !empty;
  assign out_data  = head.data;
  assign pop_fire  = out_valid && out_ready;
  assign push_fire = push_req && (!full || pop_fire);

  // Back-pressure looks at the occupancy after this edge so rx_en drops together
  // with the push that consumes the last non-reserved slot.
  assign level_next = fifo_level + LW'(push_fire) - LW'(pop_fire);
  assign hold_lvl   = (level_next >= LW'(FIFO_DEPTH - 1));

  uart_byte_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_req),
    .wr_data (wr_entry),
    .pop     (pop_fire),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_OFF;
      rx_en <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (enable) begin
            state <= hold_lvl ? ST_HOLD : ST_RUN;
            rx_en <= !hold_lvl;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_OFF;
            rx_en <= 1'b0;
          end else if (hold_lvl) begin
            state <= ST_HOLD;
            rx_en <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!enable) begin
            state <= ST_OFF;
            rx_en <= 1'b0;
          end else if (!hold_lvl) begin
            state <= ST_RUN;
            rx_en <= 1'b1;
          end
        end
        default: begin
          state <= ST_OFF;
          rx_en <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pb_err_cnt <= '0;
      sb_err_cnt <= '0;
      overflow   <= 1'b0;
    end else if (clr_stats) begin
      pb_err_cnt <= '0;
      sb_err_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      if (rx_data_ready && rx_pb_error && (pb_err_cnt != '1)) pb_err_cnt <= pb_err_cnt + 1'b1;
      if (rx_data_ready && rx_sb_error && (sb_err_cnt != '1)) sb_err_cnt <= sb_err_cnt + 1'b1;
      if (push_req && full && !pop_fire) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt  <= '0;
      idle_tmo <= 1'b0;
    end else if (rx_data_ready || (state == ST_OFF) || (tmo_cycles == '0)) begin
      tmo_cnt  <= '0;
      idle_tmo <= 1'b0;
    end else if (tmo_cnt == tmo_cycles - TMO_W'(1)) begin
      tmo_cnt  <= '0;
      idle_tmo <= 1'b1;
    end else begin
      tmo_cnt  <= tmo_cnt + 1'b1;
      idle_tmo <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller that sequences the UART RX datapath.
- Gates the receiver's enable input (RX_en) from a software enable and FIFO back-pressure.
- Captures each completed frame (byte plus parity and stop error flags) into a small byte FIFO.
- Keeps saturating error counters.
- Raises an idle-line timeout event.
- Sits between the RX receiver and the host-side consumer.

Parameters:
- FIFO_DEPTH, 4, entries in the byte FIFO; power of 2, minimum 2.
- CNT_W, 8, width of each error counter.
- TMO_W, 16, width of the idle-timeout counter and of the tmo_cycles port.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  software receive enable, level
- clr_stats  in  1  one-cycle pulse; clears counters and the sticky overflow flag
- tmo_cycles  in  TMO_W  idle-timeout threshold; 0 disables the timeout
- rx_en  out  1  drives the receiver's RX_en
- rx_data_ready  in  1  one-cycle frame-complete pulse from the receiver
- rx_data  in  8  received byte, valid with rx_data_ready
- rx_pb_error  in  1  parity error flag, valid with rx_data_ready
- rx_sb_error  in  1  stop-bit error flag, valid with rx_data_ready
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accept
- out_data  out  8  head byte
- out_err  out  2  head entry flags: {sb_error, pb_error}
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- pb_err_cnt  out  CNT_W  saturating parity-error count
- sb_err_cnt  out  CNT_W  saturating stop-error count
- overflow  out  1  sticky; a frame was lost because the FIFO was full
- idle_tmo  out  1  one-cycle timeout pulse

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in OFF.
- FSM states and transitions:
  - OFF: rx_en=0. Go to RUN when enable=1 and level<FIFO_DEPTH-1; go to HOLD when enable=1 and level>=FIFO_DEPTH-1.
  - RUN: rx_en=1. Go to HOLD when level>=FIFO_DEPTH-1 (evaluated on the registered next level); go to OFF when enable=0.
  - HOLD: rx_en=0. Go to RUN when level<FIFO_DEPTH-1 and enable=1; go to OFF when enable=0.
- rx_en is registered and equals 1 exactly when the state is RUN.
- One FIFO slot is always held in reserve. A frame already in flight when rx_en drops still completes and must be accepted.
- Frame capture:
  - rx_data_ready is accepted in any state, including OFF.
  - The entry {sb, pb, data} is written in the same cycle and is visible on out_* on the next clock.
  - Capture-to-out_valid latency: 1 cycle.
- FIFO:
  - Pop when out_valid && out_ready.
  - out_data and out_err show the head entry combinationally from the registered storage.
  - Simultaneous push and pop on a non-empty FIFO: level unchanged.
  - Simultaneous push and pop on an empty FIFO: push only, because out_valid=0.
  - Push while full and no pop: entry dropped, overflow set to 1 (sticky).
  - Pointers wrap modulo FIFO_DEPTH.
- Error counters:
  - On rx_data_ready, add rx_pb_error to pb_err_cnt and rx_sb_error to sb_err_cnt.
  - Each counter saturates at 2^CNT_W-1.
  - clr_stats has priority over a same-cycle increment: result is 0.
  - clr_stats does not touch the FIFO.
- Idle timeout:
  - The counter resets to 0 on rx_data_ready, in OFF, and when tmo_cycles=0.
  - Otherwise it increments each cycle while in RUN or HOLD.
  - When the counter equals tmo_cycles-1, idle_tmo pulses for 1 cycle and the counter restarts at 0.
- Reset mid-operation: FIFO contents discarded, counters cleared, rx_en=0 immediately (asynchronous).

Optional Feature:
- Macro: UART_RX_CTRL_DISCARD_ERR_EN.
- Defined: frames with pb or sb error are not pushed. Counters still increment, and out_err is tied to 0.
- Undefined: all frames are pushed with their flags.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding for OFF, RUN, HOLD.
  - Packed entry type rx_entry_t = {sb_err, pb_err, data[7:0]} (10 bits).
  - Error-flag bit positions.
- Sub-module uart_byte_fifo:
  - Parameterized width and depth synchronous FIFO.
  - push/pop/full/empty/level interface.
  - Same clock and reset as this block.
- FSM, counters and timeout stay in uart_rx_ctrl.

Test Plan:
- enable=1, FIFO empty, out_ready=1 -> rx_en=1 on the next clock. Pulse rx_data_ready with 0xA5, flags 0 -> out_valid=1 one cycle later, out_data=0xA5, out_err=0.
- FIFO_DEPTH=4, out_ready=0, push 3 frames -> rx_en drops to 0 after the 3rd. A 4th frame arrives anyway -> level=4, overflow=0. A 5th frame -> dropped, overflow=1, level stays 4.
- From full, pop 2 with out_ready=1 -> level=2, state returns to RUN, rx_en=1. Bytes pop in the order pushed.
- Frames with pb=1 (x3) and sb=1 (x2) -> pb_err_cnt=3, sb_err_cnt=2. With CNT_W=2, 5 parity errors -> count holds at 3. clr_stats together with an error frame -> both counts 0.
- tmo_cycles=10, enabled, no frames -> idle_tmo pulses every 10 cycles. A frame at cycle 7 -> next pulse 10 cycles after that frame. tmo_cycles=0 -> no pulses.
- Reset asserted with 2 entries queued and rx_en=1 -> immediately out_valid=0, level=0, rx_en=0, counters 0. After release with enable=1 -> RUN in 1 cycle.
